// File: rtl/buzz_pkg.sv
// Shared types for the buzzer scheduler: FSM states and active-source codes.
package buzz_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_KEY   = 2'd1;
  localparam logic [1:0] SRC_CHIME = 2'd2;
  localparam logic [1:0] SRC_ALARM = 2'd3;

endpackage

// File: rtl/buzz_phase_timer.sv
// Loadable down-counter timing one beep phase. After a load of N-1 the
// expire pulse is high during the N-th cycle of the phase, so the owner
// changes phase on the edge that closes a phase of exactly N cycles.
module buzz_phase_timer #(
  parameter int TW = 26
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expire
);

  logic [TW-1:0] cnt;
  logic          armed;

  // Count down after a load; disarm once the last count has been signalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= load_val;
      armed <= 1'b1;
    end else if (armed) begin
      if (cnt == '0) armed <= 1'b0;
      else           cnt   <= cnt - TW'(1);
    end
  end

  assign expire = armed && (cnt == '0);

endmodule

// File: rtl/buzz_sched.sv
// Buzzer scheduler: arbitrates alarm > chime > key-click for one tone path
// and sequences the ON/OFF beep phases. All outputs are registered.
module buzz_sched
  import buzz_pkg::*;
#(
  parameter int HALF_SEC_CYC = 50_000_000,
  parameter int KEY_CYC      = 5_000_000,
  parameter int CNT_W        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alarm_req,
  input  logic             chime_req,
  input  logic [CNT_W-1:0] chime_count,
  input  logic             key_req,
  output logic             buzz_en,
  output logic             busy,
  output logic [1:0]       src,
  output logic             chime_done
);

  localparam int TW = $clog2(HALF_SEC_CYC);
  localparam logic [TW-1:0] HALF_LD = TW'(HALF_SEC_CYC - 1);
  localparam logic [TW-1:0] KEY_LD  = TW'(KEY_CYC - 1);

  state_t           state, state_n;
  logic [1:0]       src_n;
  logic             chime_pend, pend_n;
  logic [CNT_W-1:0] beep_cnt, beep_n;
  logic [CNT_W-1:0] chime_lat, count_n;
  logic [CNT_W-1:0] start_cnt;
  logic             done_n;
  logic             load;
  logic [TW-1:0]    load_val;
  logic             expire;

  buzz_phase_timer #(
    .TW (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );

  // A fresh chime request overrides whatever count is already latched.
  assign start_cnt = chime_req ? chime_count : chime_lat;

  // Next-state, bookkeeping and next-output decode.
  always_comb begin
    state_n  = state;
    src_n    = src;
    pend_n   = chime_pend;
    beep_n   = beep_cnt;
    count_n  = chime_lat;
    done_n   = 1'b0;
    load     = 1'b0;
    load_val = HALF_LD;
    case (state)
      IDLE: begin
        if (alarm_req) begin
          state_n = ON;
          src_n   = SRC_ALARM;
          load    = 1'b1;
          if (chime_req) begin
            pend_n  = 1'b1;
            count_n = chime_count;
          end
        end else if (chime_req || chime_pend) begin
          pend_n  = 1'b0;
          count_n = start_cnt;
          if (start_cnt != '0) begin
            beep_n  = CNT_W'(1);
            state_n = ON;
            src_n   = SRC_CHIME;
            load    = 1'b1;
          end else begin
            // Zero-beep chime completes at once without sounding.
            done_n = 1'b1;
          end
        end else if (key_req) begin
          state_n  = ON;
          src_n    = SRC_KEY;
          load     = 1'b1;
          load_val = KEY_LD;
        end
      end
      ON, OFF: begin
        if (src == SRC_ALARM) begin
          if (chime_req) begin
            pend_n  = 1'b1;
            count_n = chime_count;
          end
          if (!alarm_req) begin
            state_n = IDLE;
            src_n   = SRC_NONE;
          end else if (expire) begin
            state_n = (state == ON) ? OFF : ON;
            load    = 1'b1;
          end
        end else if (alarm_req) begin
          // Alarm preempts; an interrupted chime is replayed from beep 1 later.
          state_n = ON;
          src_n   = SRC_ALARM;
          load    = 1'b1;
          if (src == SRC_CHIME) pend_n = 1'b1;
        end else if (expire) begin
          if (src == SRC_KEY) begin
            state_n = IDLE;
            src_n   = SRC_NONE;
          end else if (state == ON) begin
            state_n = OFF;
            load    = 1'b1;
          end else if (beep_cnt < chime_lat) begin
            beep_n  = beep_cnt + CNT_W'(1);
            state_n = ON;
            load    = 1'b1;
          end else begin
            state_n = IDLE;
            src_n   = SRC_NONE;
            done_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        src_n   = SRC_NONE;
      end
    endcase
  end

  // State, chime bookkeeping and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      src        <= SRC_NONE;
      chime_pend <= 1'b0;
      beep_cnt   <= '0;
      chime_lat  <= '0;
      buzz_en    <= 1'b0;
      busy       <= 1'b0;
      chime_done <= 1'b0;
    end else begin
      state      <= state_n;
      src        <= src_n;
      chime_pend <= pend_n;
      beep_cnt   <= beep_n;
      chime_lat  <= count_n;
      buzz_en    <= (state_n == ON);
      busy       <= (state_n != IDLE);
      chime_done <= done_n;
    end
  end

endmodule

// File: tb/tb_buzz_sched.sv
// Scoreboard bench for buzz_sched with short phases (4-cycle beeps, 2-cycle key).
// Each expected cycle is {buzz_en, busy, src, chime_done}.
module tb_buzz_sched;

  localparam int CNT_W = 5;

  localparam logic [4:0] IDLE_V = 5'b0_0_00_0;
  localparam logic [4:0] DONE_V = 5'b0_0_00_1;
  localparam logic [4:0] ON_K   = 5'b1_1_01_0;
  localparam logic [4:0] ON_C   = 5'b1_1_10_0;
  localparam logic [4:0] OFF_C  = 5'b0_1_10_0;
  localparam logic [4:0] ON_A   = 5'b1_1_11_0;
  localparam logic [4:0] OFF_A  = 5'b0_1_11_0;

  logic             clk;
  logic             rst;
  logic             alarm_req;
  logic             chime_req;
  logic [CNT_W-1:0] chime_count;
  logic             key_req;
  logic             buzz_en;
  logic             busy;
  logic [1:0]       src;
  logic             chime_done;

  logic [4:0] obs_v;
  logic [4:0] exp_v;
  logic [4:0] exp_q[$];
  int         n_checks;
  int         n_fail;

  buzz_sched #(
    .HALF_SEC_CYC (4),
    .KEY_CYC      (2),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alarm_req   (alarm_req),
    .chime_req   (chime_req),
    .chime_count (chime_count),
    .key_req     (key_req),
    .buzz_en     (buzz_en),
    .busy        (busy),
    .src         (src),
    .chime_done  (chime_done)
  );

  assign obs_v = {buzz_en, busy, src, chime_done};

  always #5 clk = ~clk;

  function automatic void push(input logic [4:0] v, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(v);
  endfunction

  function automatic void push_chime(input int beeps);
    for (int b = 0; b < beeps; b++) begin
      push(ON_C, 4);
      push(OFF_C, 4);
    end
  endfunction

  task automatic test_reset;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (obs_v !== IDLE_V) begin
        n_fail++;
        $display("FAIL reset_hold got=%b exp=%b", obs_v, IDLE_V);
      end
    end
    rst = 1'b0;
    exp_q.delete();
    push(IDLE_V, 50);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_idle idx=%0d got=%b exp=%b", i, obs_v, exp_v);
      end
    end
    // Start a chime, then hit reset in the middle of the first ON phase.
    chime_count = 5'd3;
    chime_req   = 1'b1;
    push(ON_C, 2);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      chime_req = 1'b0;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_pre_on idx=%0d got=%b exp=%b", i, obs_v, exp_v);
      end
    end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (obs_v !== IDLE_V) begin
      n_fail++;
      $display("FAIL reset_async got=%b exp=%b", obs_v, IDLE_V);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    push(IDLE_V, 12);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_after idx=%0d got=%b exp=%b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_chime(input logic [CNT_W-1:0] cnt);
    exp_q.delete();
    push_chime(int'(cnt));
    push(DONE_V, 1);
    push(IDLE_V, 3);
    chime_count = cnt;
    chime_req   = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      chime_req = 1'b0;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL chime_%0d idx=%0d got=%b exp=%b", cnt, i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_key;
    exp_q.delete();
    push(ON_K, 2);
    push(IDLE_V, 4);
    key_req = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      key_req = 1'b0;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL key idx=%0d got=%b exp=%b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_key_during_chime;
    exp_q.delete();
    push_chime(2);
    push(DONE_V, 1);
    push(IDLE_V, 4);
    chime_count = 5'd2;
    chime_req   = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      chime_req = 1'b0;
      key_req   = 1'b0;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL key_in_chime idx=%0d got=%b exp=%b", i, obs_v, exp_v);
      end
      if (i == 1 || i == 5 || i == 12 || i == 15) key_req = 1'b1;
    end
  endtask

  task automatic test_alarm;
    exp_q.delete();
    for (int k = 0; k < 18; k++) push(((k / 4) % 2 == 1) ? OFF_A : ON_A, 1);
    push(IDLE_V, 4);
    alarm_req = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL alarm idx=%0d got=%b exp=%b", i, obs_v, exp_v);
      end
      if (i == 17) alarm_req = 1'b0;
    end
  endtask

  task automatic test_preempt;
    exp_q.delete();
    push_chime(1);
    push(ON_C, 2);
    push(ON_A, 4);
    push(OFF_A, 2);
    push(IDLE_V, 1);
    push_chime(5);
    push(DONE_V, 1);
    push(IDLE_V, 4);
    chime_count = 5'd5;
    chime_req   = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      chime_req = 1'b0;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL preempt idx=%0d got=%b exp=%b", i, obs_v, exp_v);
      end
      if (i == 9)  alarm_req = 1'b1;
      if (i == 15) alarm_req = 1'b0;
    end
  endtask

  task automatic test_same_cycle;
    exp_q.delete();
    push_chime(2);
    push(DONE_V, 1);
    push(IDLE_V, 5);
    chime_count = 5'd2;
    chime_req   = 1'b1;
    key_req     = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      chime_req = 1'b0;
      key_req   = 1'b0;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL same_cycle idx=%0d got=%b exp=%b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_chime_during_alarm;
    exp_q.delete();
    push(ON_A, 4);
    push(OFF_A, 4);
    push(ON_A, 2);
    push(IDLE_V, 1);
    push_chime(4);
    push(DONE_V, 1);
    push(IDLE_V, 3);
    alarm_req = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      chime_req = 1'b0;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL chime_in_alarm idx=%0d got=%b exp=%b", i, obs_v, exp_v);
      end
      if (i == 1) begin
        chime_count = 5'd1;
        chime_req   = 1'b1;
      end
      if (i == 3) begin
        chime_count = 5'd4;
        chime_req   = 1'b1;
      end
      if (i == 9) alarm_req = 1'b0;
    end
  endtask

  initial begin
    clk         = 1'b0;
    rst         = 1'b1;
    alarm_req   = 1'b0;
    chime_req   = 1'b0;
    chime_count = '0;
    key_req     = 1'b0;
    n_checks    = 0;
    n_fail      = 0;
    test_reset;
    test_chime(5'd3);
    test_chime(5'd0);
    test_chime(5'd31);
    test_key;
    test_key_during_chime;
    test_alarm;
    test_preempt;
    test_same_cycle;
    test_chime_during_alarm;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
